// File: rtl/scnn_rle_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : scnn_rle_compressor
//  Purpose  : Zero-run-length compressor for sparse activation frames. Dense
//             elements arrive in raster order; nonzero values are packed into
//             groups of up to four lanes. Each lane carries the value and the
//             number of zeros that preceded it. out_offset gives the dense
//             index from which lane 0's run is measured, so a decoder rebuilds
//             coordinates as:
//                 orig[0] = out_offset + out_comp_ind[0]
//                 orig[k] = orig[k-1]  + out_comp_ind[k] + 1
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             start, frame_len    - frame kick-off (sampled only when idle)
//             in_data/in_valid/in_ready
//                                 - dense element stream
//             out_val/out_comp_ind/out_offset/out_cnt/out_last
//                                 - compressed group, lane 0 in the LSBs
//             out_valid/out_ready - group handshake
//             busy                - any state other than idle
//  Revision : 1.0  initial release
// ============================================================================
module scnn_rle_compressor #(
    parameter int DATA_W = 8,
    parameter int IND_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           frame_len,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*DATA_W-1:0]  out_val,
    output logic [4*IND_W-1:0]   out_comp_ind,
    output logic [IND_W-1:0]     out_offset,
    output logic [2:0]           out_cnt,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int c_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0]        r_frame_len;
    logic [7:0]        r_elem_cnt;   // dense index of the next element to accept
    logic [IND_W-1:0]  r_run;        // zeros seen since the last nonzero
    logic [IND_W-1:0]  r_offset;
    logic [2:0]        r_lane;       // lanes filled in the current group
    logic              r_last;
    logic [DATA_W-1:0] r_val  [c_LANES];
    logic [IND_W-1:0]  r_comp [c_LANES];

    logic w_accept;
    logic w_nonzero;
    logic w_last_elem;
    logic w_fill_last_lane;
    logic w_trigger;

    assign w_accept         = in_valid && (r_state == S_COLLECT);
    assign w_nonzero        = (in_data != '0);
    assign w_last_elem      = (r_elem_cnt == (r_frame_len - 8'd1));
    assign w_fill_last_lane = w_nonzero && (r_lane == 3'd3);
    // A group closes either when lane 3 fills or when the frame runs out.
    assign w_trigger        = w_accept && (w_last_elem || w_fill_last_lane);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // An empty frame still yields one (empty, last) group.
                    w_state_next = (frame_len == 8'd0) ? S_EMIT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_trigger) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_state_next = r_last ? S_IDLE : S_COLLECT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: counters and lane registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_len <= 8'd0;
            r_elem_cnt  <= 8'd0;
            r_run       <= '0;
            r_offset    <= '0;
            r_lane      <= 3'd0;
            r_last      <= 1'b0;
            for (int i = 0; i < c_LANES; i++) begin
                r_val[i]  <= '0;
                r_comp[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame_len <= frame_len;
                        r_elem_cnt  <= 8'd0;
                        r_run       <= '0;
                        r_offset    <= '0;
                        r_lane      <= 3'd0;
                        r_last      <= (frame_len == 8'd0);
                        for (int i = 0; i < c_LANES; i++) begin
                            r_val[i]  <= '0;
                            r_comp[i] <= '0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_elem_cnt <= r_elem_cnt + 8'd1;
                        if (w_nonzero) begin
                            r_val[r_lane[1:0]]  <= in_data;
                            r_comp[r_lane[1:0]] <= r_run;
                            r_lane              <= r_lane + 3'd1;
                            r_run               <= '0;
                        end else begin
                            r_run <= r_run + IND_W'(1);
                        end
                        if (w_trigger) begin
                            r_last <= w_last_elem;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_lane <= 3'd0;
                        for (int i = 0; i < c_LANES; i++) begin
                            r_val[i]  <= '0;
                            r_comp[i] <= '0;
                        end
                        if (r_last) begin
                            r_last   <= 1'b0;
                            r_offset <= '0;
                        end else begin
                            // A non-last group always ends on a lane-3 accept,
                            // so the element counter already points one past
                            // that element: exactly the next group's base.
                            r_offset <= IND_W'(r_elem_cnt);
                        end
                    end
                end
                default: begin
                    r_lane <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready   = (r_state == S_COLLECT);
    assign out_valid  = (r_state == S_EMIT);
    assign busy       = (r_state != S_IDLE);
    assign out_cnt    = r_lane;
    assign out_offset = r_offset;
    assign out_last   = r_last;

    // Unfilled lanes read as zero because lanes are cleared on every new
    // group and only written as nonzero values arrive.
    generate
        for (genvar g = 0; g < c_LANES; g++) begin : g_lane
            assign out_val[g*DATA_W +: DATA_W]     = r_val[g];
            assign out_comp_ind[g*IND_W +: IND_W]  = r_comp[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_scnn_rle_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scnn_rle_compressor
//  Purpose  : Directed self-checking bench for scnn_rle_compressor. Frames
//             with hand-computed groups are streamed in; emitted groups are
//             captured and compared with constant expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scnn_rle_compressor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  frame_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_val;
    logic [31:0] out_comp_ind;
    logic [7:0]  out_offset;
    logic [2:0]  out_cnt;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  fr_data [$];
    int          n_grp;
    logic [31:0] g_val  [4];
    logic [31:0] g_comp [4];
    logic [7:0]  g_off  [4];
    logic [2:0]  g_cnt  [4];
    logic        g_last [4];

    scnn_rle_compressor #(
        .DATA_W (8),
        .IND_W  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .frame_len    (frame_len),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_val      (out_val),
        .out_comp_ind (out_comp_ind),
        .out_offset   (out_offset),
        .out_cnt      (out_cnt),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_group(input int g, input string tag, input logic [31:0] val,
                               input logic [31:0] comp, input logic [7:0] off,
                               input logic [2:0] cnt, input logic last);
        check({tag, "_val"},  g_val[g],  val);
        check({tag, "_comp"}, g_comp[g], comp);
        check({tag, "_off"},  g_off[g],  off);
        check({tag, "_cnt"},  g_cnt[g],  cnt);
        check({tag, "_last"}, g_last[g], last);
    endtask

    // Starts a frame and streams fr_data, capturing every emitted group.
    // stall: cycles out_ready is held low on the first group.
    // poke_start: raise start alongside element 1 (must be ignored).
    task automatic run_frame(input int len, input int stall, input bit poke_start);
        int          idx        = 0;
        int          cyc        = 0;
        bit          done       = 1'b0;
        int          stall_left = stall;
        bit          snapped    = 1'b0;
        bit          exp_valid  = 1'b0;
        logic [31:0] snap_val   = '0;
        logic [31:0] snap_comp  = '0;
        n_grp = 0;
        for (int i = 0; i < 4; i++) begin
            g_val[i] = 'x; g_comp[i] = 'x; g_off[i] = 'x; g_cnt[i] = 'x; g_last[i] = 1'bx;
        end
        @(negedge clk);
        start     = 1'b1;
        frame_len = len[7:0];
        out_ready = 1'b1;
        @(negedge clk);
        frame_len = 8'hA5;
        while (!done && cyc < 300) begin
            start    = 1'b0;
            in_valid = 1'b0;
            if (exp_valid) begin
                check("latency1_valid", out_valid, 1'b1);
                exp_valid = 1'b0;
            end
            if (out_valid) begin
                if (!snapped) begin
                    snap_val  = out_val;
                    snap_comp = out_comp_ind;
                    snapped   = 1'b1;
                end else begin
                    check("stall_val",  out_val,      snap_val);
                    check("stall_comp", out_comp_ind, snap_comp);
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    check("stall_in_ready", in_ready, 1'b0);
                    if (idx < len) begin
                        in_valid = 1'b1;
                        in_data  = fr_data[idx];
                    end
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (n_grp < 4) begin
                        g_val[n_grp]  = out_val;
                        g_comp[n_grp] = out_comp_ind;
                        g_off[n_grp]  = out_offset;
                        g_cnt[n_grp]  = out_cnt;
                        g_last[n_grp] = out_last;
                    end
                    n_grp++;
                    snapped = 1'b0;
                    if (out_last) done = 1'b1;
                end
            end else if (idx < len) begin
                in_valid = 1'b1;
                in_data  = fr_data[idx];
                if (poke_start && idx == 1) begin
                    start     = 1'b1;
                    frame_len = 8'd1;
                end
                if (in_ready) begin
                    if (idx == len - 1) exp_valid = 1'b1;
                    idx++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("frame_done", done, 1'b1);
        check("frame_consumed", idx, len);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        frame_len = 8'd0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  in_ready,     1'b0);
        check("rst_out_valid", out_valid,    1'b0);
        check("rst_out_last",  out_last,     1'b0);
        check("rst_busy",      busy,         1'b0);
        check("rst_out_val",   out_val,      32'h0);
        check("rst_comp",      out_comp_ind, 32'h0);
        check("rst_offset",    out_offset,   8'h0);
        check("rst_cnt",       out_cnt,      3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single full group ending exactly on the last element
        fr_data = {8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd1, 8'd0, 8'd9};
        run_frame(8, 0, 1'b0);
        check("t1_ngrp", n_grp, 1);
        check_group(0, "t1_g0", 32'h09010705, 32'h01000201, 8'd0, 3'd4, 1'b1);
        check("t1_idle", busy, 1'b0);

        // Two groups: full first group, partial last group with offset 4
        fr_data = {8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
        run_frame(10, 0, 1'b0);
        check("t2_ngrp", n_grp, 2);
        check_group(0, "t2_gA", 32'h06050403, 32'h00000000, 8'd0, 3'd4, 1'b0);
        check_group(1, "t2_gB", 32'h00000002, 32'h00000002, 8'd4, 3'd1, 1'b1);

        // All-zero frame gives one empty last group
        fr_data = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(5, 0, 1'b0);
        check("t3_ngrp", n_grp, 1);
        check_group(0, "t3_g0", 32'h0, 32'h0, 8'd0, 3'd0, 1'b1);

        // Back-pressure on the first group for 3 cycles
        fr_data = {8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
        run_frame(10, 3, 1'b0);
        check("t4_ngrp", n_grp, 2);
        check_group(0, "t4_gA", 32'h06050403, 32'h00000000, 8'd0, 3'd4, 1'b0);
        check_group(1, "t4_gB", 32'h00000002, 32'h00000002, 8'd4, 3'd1, 1'b1);

        // Reset in the middle of a frame
        @(negedge clk);
        start     = 1'b1;
        frame_len = 8'd10;
        @(negedge clk);
        start = 1'b0;
        fr_data = {8'd0, 8'd0, 8'd7, 8'd0};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fr_data[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t5_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready",  in_ready,     1'b0);
        check("t5_rst_out_valid", out_valid,    1'b0);
        check("t5_rst_busy",      busy,         1'b0);
        check("t5_rst_cnt",       out_cnt,      3'd0);
        check("t5_rst_val",       out_val,      32'h0);
        check("t5_rst_comp",      out_comp_ind, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fr_data = {8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
        run_frame(10, 0, 1'b0);
        check("t5_ngrp", n_grp, 2);
        check_group(0, "t5_gA", 32'h06050403, 32'h00000000, 8'd0, 3'd4, 1'b0);
        check_group(1, "t5_gB", 32'h00000002, 32'h00000002, 8'd4, 3'd1, 1'b1);

        // Zero-length frame: group valid the next cycle
        @(negedge clk);
        start     = 1'b1;
        frame_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("t6_valid",  out_valid,  1'b1);
        check("t6_cnt",    out_cnt,    3'd0);
        check("t6_last",   out_last,   1'b1);
        check("t6_offset", out_offset, 8'd0);
        @(negedge clk);
        check("t6_idle", busy, 1'b0);

        // start during COLLECT is ignored
        fr_data = {8'd0, 8'd4, 8'd0};
        run_frame(3, 0, 1'b1);
        check("t7_ngrp", n_grp, 1);
        check_group(0, "t7_g0", 32'h00000004, 32'h00000001, 8'd0, 3'd1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
